// File: rtl/fib_pkg.sv
// Shared types and elaboration helpers for the Fibonacci index decoder.
package fib_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        ITER = 1'b1
    } state_e;

    // Largest n with F(n) < 2**width; the decoder's index never exceeds this.
    function automatic int fib_max_idx(input int width);
        longint unsigned a;
        longint unsigned b;
        longint unsigned t;
        longint unsigned lim;
        int              n;
        a   = 0;
        b   = 1;
        n   = 1;
        lim = 64'd1 << width;
        while (a + b < lim) begin
            t = a + b;
            a = b;
            b = t;
            n = n + 1;
        end
        return n;
    endfunction

    // Direct evaluation of F(n), used to cross-check reported matches.
    function automatic longint unsigned fib_val(input int n);
        longint unsigned a;
        longint unsigned b;
        longint unsigned t;
        a = 0;
        b = 1;
        for (int i = 0; i < n; i++) begin
            t = a + b;
            a = b;
            b = t;
        end
        return a;
    endfunction

endpackage

// File: rtl/fib_step.sv
// One Fibonacci step: WIDTH-bit add with the carry-out exposed as overflow.
module fib_step #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] sum_o,
    output logic             carry_o
);

    logic [WIDTH:0] sum_w;

    // Widen by one bit so a wrapped sum can never pass for a sequence term.
    always_comb sum_w = {1'b0, a_i} + {1'b0, b_i};

    assign sum_o   = sum_w[WIDTH-1:0];
    assign carry_o = sum_w[WIDTH];

endmodule

// File: rtl/fibonacci_index_decoder.sv
// Fibonacci index decoder: walks F(n) upward until it meets or passes the
// captured operand, then reports is_fib and the index.
// Optional: define FIB_DEC_SVA_EN to compile in protocol/datapath assertions.
module fibonacci_index_decoder
    import fib_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int IDX_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] value,
    output logic             busy,
    output logic             done,
    output logic             is_fib,
    output logic [IDX_W-1:0] index
);

    // Index register must hold the largest reachable index.
    if ((1 << IDX_W) <= fib_max_idx(WIDTH)) begin : g_idx_w_check
        $error("IDX_W too narrow for WIDTH");
    end

    state_e           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] v_q;
    logic [IDX_W-1:0] idx_q;
    logic             busy_q;
    logic             done_q;
    logic             is_fib_q;
    logic [IDX_W-1:0] index_q;

    logic [WIDTH-1:0] sum;
    logic             carry;

    fib_step #(.WIDTH(WIDTH)) u_step (
        .a_i     (a_q),
        .b_i     (b_q),
        .sum_o   (sum),
        .carry_o (carry)
    );

    // Control FSM plus datapath registers; results are registered on finish.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            v_q      <= '0;
            idx_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            is_fib_q <= 1'b0;
            index_q  <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        v_q <= value;
                        if (value == '0) begin
                            done_q   <= 1'b1;
                            is_fib_q <= 1'b1;
                            index_q  <= '0;
                        end else begin
                            a_q     <= '0;
                            b_q     <= WIDTH'(1);
                            idx_q   <= IDX_W'(1);
                            busy_q  <= 1'b1;
                            state_q <= ITER;
                        end
                    end
                end
                ITER: begin
                    if (b_q == v_q) begin
                        done_q   <= 1'b1;
                        is_fib_q <= 1'b1;
                        index_q  <= idx_q;
                        busy_q   <= 1'b0;
                        state_q  <= IDLE;
                    end else if (b_q > v_q) begin
                        // Overshot: report the last index whose term was below v.
                        done_q   <= 1'b1;
                        is_fib_q <= 1'b0;
                        index_q  <= idx_q - 1'b1;
                        busy_q   <= 1'b0;
                        state_q  <= IDLE;
                    end else if (carry) begin
                        // Next term no longer fits: v lies above the last representable term.
                        done_q   <= 1'b1;
                        is_fib_q <= 1'b0;
                        index_q  <= idx_q;
                        busy_q   <= 1'b0;
                        state_q  <= IDLE;
                    end else begin
                        a_q   <= b_q;
                        b_q   <= sum;
                        idx_q <= idx_q + 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign is_fib = is_fib_q;
    assign index  = index_q;

`ifdef FIB_DEC_SVA_EN
    // A zero operand restarted in the done cycle legitimately finishes again next cycle.
    a_done_pulse: assert property (@(posedge clk) disable iff (rst)
        done && !(start && value == '0) |=> !done);

    a_busy_done_excl: assert property (@(posedge clk) disable iff (rst)
        !(busy && done));

    a_index_range: assert property (@(posedge clk) disable iff (rst)
        int'(index) < (1 << IDX_W));

    a_no_wrap_term: assert property (@(posedge clk) disable iff (rst)
        (state_q == ITER && b_q < v_q && !carry) |=> (b_q >= a_q));

    a_is_fib_ok: assert property (@(posedge clk) disable iff (rst)
        (done && is_fib) |-> (fib_val(int'(index)) == 64'(v_q)));
`endif

endmodule

// File: tb/tb_fibonacci_index_decoder.sv
// Scoreboard bench for fibonacci_index_decoder: expectations come from an
// independent reference model and are queued at issue, popped at done.
module tb_fibonacci_index_decoder;

    localparam int W  = 8;
    localparam int IW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [W-1:0]  value;
    logic          busy;
    logic          done;
    logic          is_fib;
    logic [IW-1:0] index;

    fibonacci_index_decoder #(.WIDTH(W), .IDX_W(IW)) dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .value  (value),
        .busy   (busy),
        .done   (done),
        .is_fib (is_fib),
        .index  (index)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          f;
        logic [IW-1:0] idx;
        int            lat;
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    // Reference: table of F(n), pick smallest n with F(n)==v, else largest F(n)<v.
    function automatic exp_t model(input int v);
        longint f[0:20];
        int     n;
        exp_t   e;
        f[0] = 0;
        f[1] = 1;
        for (int i = 2; i <= 20; i++) f[i] = f[i-1] + f[i-2];
        if (v == 0) begin
            e.f = 1'b1; e.idx = '0; e.lat = 1;
            return e;
        end
        n = 1;
        while (f[n+1] <= v && f[n] != v) n++;
        e.idx = IW'(n);
        if (f[n] == v) begin
            e.f = 1'b1; e.lat = n + 1;
        end else begin
            e.f   = 1'b0;
            e.lat = (f[n+1] < (64'd1 << W)) ? n + 2 : n + 1;
        end
        return e;
    endfunction

    // Drive start through one rising edge (the accept edge) and queue the expectation.
    task automatic issue(input logic [W-1:0] v);
        start = 1'b1;
        value = v;
        exp_q.push_back(model(int'(v)));
        @(posedge clk);
    endtask

    // Bounded wait for done; reports cycle number and whether busy behaved.
    task automatic wait_done(output int lat, output bit busy_ok);
        lat     = -1;
        busy_ok = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (done) begin
                lat = c;
                if (busy) busy_ok = 1'b0;
                break;
            end
            if (!busy) busy_ok = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; value = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        total++;
        if ({busy, done, is_fib, index} !== '0) begin
            bad++;
            $display("FAIL reset_outputs got=%b exp=0", {busy, done, is_fib, index});
        end
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            total++;
            if ({busy, done, is_fib, index} !== '0) begin
                bad++;
                $display("FAIL idle_outputs cyc=%0d got=%b exp=0", c, {busy, done, is_fib, index});
            end
        end
    endtask

    task automatic test_values(input string name, input logic [W-1:0] v);
        int   lat;
        bit   bok;
        exp_t e;
        @(negedge clk);
        issue(v);
        wait_done(lat, bok);
        e = exp_q.pop_front();
        total++;
        if (lat !== e.lat) begin
            bad++;
            $display("FAIL %s_latency v=%0d got=%0d exp=%0d", name, v, lat, e.lat);
        end
        total++;
        if ({is_fib, index} !== {e.f, e.idx}) begin
            bad++;
            $display("FAIL %s_result v=%0d got=%b/%0d exp=%b/%0d", name, v, is_fib, index, e.f, e.idx);
        end
        total++;
        if (!bok) begin
            bad++;
            $display("FAIL %s_busy v=%0d got=bad exp=busy_until_done", name, v);
        end
    endtask

    task automatic test_busy_ignore();
        int   lat;
        exp_t e;
        bit   extra;
        @(negedge clk);
        issue(8'd100);
        lat = -1;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            start = (c == 3);
            if (c == 3) value = 8'd5;
            if (done) begin lat = c; break; end
        end
        start = 1'b0;
        e = exp_q.pop_front();
        total++;
        if (lat !== e.lat || {is_fib, index} !== {e.f, e.idx}) begin
            bad++;
            $display("FAIL busy_ignore got=lat%0d/%b/%0d exp=lat%0d/%b/%0d", lat, is_fib, index, e.lat, e.f, e.idx);
        end
        extra = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (done || busy) extra = 1'b1;
        end
        total++;
        if (extra !== 1'b0) begin
            bad++;
            $display("FAIL busy_ignore_extra got=activity exp=none");
        end
        total++;
        if ({is_fib, index} !== {e.f, e.idx}) begin
            bad++;
            $display("FAIL result_hold got=%b/%0d exp=%b/%0d", is_fib, index, e.f, e.idx);
        end
    endtask

    task automatic test_rst_mid();
        int   lat;
        bit   bok;
        bit   extra;
        exp_t e;
        @(negedge clk);
        issue(8'd233);
        exp_q.delete();
        for (int c = 1; c <= 4; c++) begin
            @(negedge clk);
            start = 1'b0;
        end
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        total++;
        if ({busy, done, is_fib, index} !== '0) begin
            bad++;
            $display("FAIL rst_mid_outputs got=%b exp=0", {busy, done, is_fib, index});
        end
        extra = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (done || busy) extra = 1'b1;
        end
        total++;
        if (extra !== 1'b0) begin
            bad++;
            $display("FAIL rst_mid_no_done got=activity exp=none");
        end
        issue(8'd21);
        wait_done(lat, bok);
        e = exp_q.pop_front();
        total++;
        if (lat !== e.lat || {is_fib, index} !== {e.f, e.idx} || !bok) begin
            bad++;
            $display("FAIL rst_mid_restart got=lat%0d/%b/%0d exp=lat%0d/%b/%0d", lat, is_fib, index, e.lat, e.f, e.idx);
        end
    endtask

    task automatic test_back_to_back();
        int   lat;
        bit   bok;
        exp_t e;
        logic [W-1:0] vals [4];
        vals[0] = 8'd8; vals[1] = 8'd0; vals[2] = 8'd0; vals[3] = 8'd50;
        @(negedge clk);
        issue(vals[0]);
        for (int i = 0; i < 4; i++) begin
            wait_done(lat, bok);
            e = exp_q.pop_front();
            total++;
            if (lat !== e.lat || {is_fib, index} !== {e.f, e.idx} || !bok) begin
                bad++;
                $display("FAIL back_to_back_%0d v=%0d got=lat%0d/%b/%0d exp=lat%0d/%b/%0d",
                         i, vals[i], lat, is_fib, index, e.lat, e.f, e.idx);
            end
            if (i < 3) issue(vals[i+1]);
        end
    endtask

    task automatic test_sweep();
        logic [W-1:0] v;
        for (int i = 0; i < 24; i++) begin
            v = W'($urandom_range(0, 255));
            test_values("sweep", v);
        end
    endtask

    initial begin
        test_reset();
        test_values("zero", 8'd0);
        test_values("fib13", 8'd13);
        test_values("fib1", 8'd1);
        test_values("fib2", 8'd2);
        test_values("nonfib100", 8'd100);
        test_values("nonfib4", 8'd4);
        test_values("ovf255", 8'd255);
        test_values("ovf234", 8'd234);
        test_values("fib233", 8'd233);
        test_busy_ignore();
        test_rst_mid();
        test_back_to_back();
        test_sweep();
        total++;
        if (exp_q.size() !== 0) begin
            bad++;
            $display("FAIL scoreboard_drain got=%0d exp=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fibonacci_index_decoder.md
# fibonacci_index_decoder

Inverse of the Fibonacci generator. It accepts an unsigned value and iterates the Fibonacci sequence until it reaches or passes that value. It reports whether the value is a Fibonacci number and gives its index. It sits on the consuming side of the generator's `n`/`fib` interface and is used to check generator output and to map values back to indices.

## Interface
- `WIDTH`, 8: width of the input value in bits.
- `IDX_W`, 4: width of the index output; must satisfy 2^IDX_W > 1.45*WIDTH+2.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst` input 1: reset, synchronous and active-high.
- `start` input 1: request; sampled only when the FSM is in IDLE.
- `value` input WIDTH: operand, captured on an accepted `start`.
- `busy` output 1: high while a decode is in progress.
- `done` output 1: one-cycle pulse; result valid.
- `is_fib` output 1: the captured value equals F(index).
- `index` output IDX_W: result index.

## Operation
- Sequence convention: F(0)=0, F(1)=1, F(n)=F(n-1)+F(n-2).
- Internal registers:
  - `a` and `b`, WIDTH bits each, holding consecutive terms.
  - `idx`, IDX_W bits.
  - `v`, WIDTH bits, holding the captured operand.
- FSM states: IDLE and ITER.
- IDLE with `start`=1:
  - Capture `v` = `value`.
  - If `value`==0, finish immediately with `is_fib`=1, `index`=0, and stay in IDLE.
  - Otherwise load `a`=0, `b`=1, `idx`=1, and go to ITER.
- ITER, evaluated once per cycle:
  - If `b`==`v`: finish with `is_fib`=1, `index`=`idx`.
  - Else if `b`>`v`: finish with `is_fib`=0, `index`=`idx`-1, the largest n with F(n)<`v`.
  - Else if `a`+`b` overflows WIDTH bits: finish with `is_fib`=0, `index`=`idx`.
  - Else update `a`←`b`, `b`←`a`+`b`, `idx`←`idx`+1.
- Overflow detection uses a WIDTH+1-bit sum; the carry-out is the overflow flag. Wrap-around is never used as a sequence term.
- Finishing means:
  - `done` is registered high for the next cycle.
  - `is_fib` and `index` are registered.
  - The FSM returns to IDLE.
- For `value`=1, the match occurs at `idx`=1, so the reported index is 1, not 2.
- `is_fib` and `index` hold their last result until the next `done`.
- `start` while `busy` is ignored. A change on `value` after capture is ignored.
- `rst` mid-decode:
  - Next cycle the FSM is in IDLE.
  - `busy`, `done`, `is_fib` and `index` are all 0.
  - No `done` is emitted for the aborted request.

## Timing
- Reset values: `busy`=0, `done`=0, `is_fib`=0, `index`=0, FSM in IDLE.
- The accept cycle is cycle 0.
- `busy`=1 from cycle 1 through the deciding ITER cycle.
- Latency of `done`:
  - `value`=0: cycle 1.
  - `value`=F(k) with k≥1: cycle k+1.
  - Non-Fibonacci `value` between F(k) and F(k+1): cycle k+2, or cycle k+1 when the next sum overflows.
- Worst case for WIDTH=8 (`value`≥234): the decision is made at `idx`=13, and `done` is at cycle 14.
- `done` and `busy` are never high in the same cycle.
- In the `done` cycle the FSM is already in IDLE, so a `start` in that cycle is accepted (back-to-back operation).

## Configuration
- `FIB_DEC_SVA_EN` defined: the block compiles in concurrent assertions, all disabled during `rst`:
  - `done` is a single-cycle pulse.
  - `busy` and `done` are mutually exclusive.
  - `index` < 2^IDX_W.
  - No carry-out while `b`<`v` is used as a term.
  - `is_fib` implies the recomputed F(`index`) equals the captured value.
- `FIB_DEC_SVA_EN` undefined: no assertion code is present. Functional behaviour is identical.

## Structure
- Package `fib_pkg` holds:
  - The state enum type (IDLE, ITER).
  - A constant function `fib_max_idx(WIDTH)`, giving the largest n with F(n) < 2^WIDTH, used to size-check `IDX_W` at elaboration.
- Sub-module `fib_step`: a combinational WIDTH-bit adder. It returns the sum and the carry-out (overflow flag) and is instantiated once in the datapath.

## Test plan
- Reset, then idle 5 cycles → all outputs 0; `busy` never asserts.
- `value`=0, `start` pulse → `done` at cycle 1, `is_fib`=1, `index`=0.
- `value`=13 → `done` at cycle 8, `is_fib`=1, `index`=7; `value`=1 → `done` at cycle 2, `index`=1.
- `value`=100 → `done` at cycle 13, `is_fib`=0, `index`=11 (F(11)=89 < 100 < F(12)=144).
- `value`=255 → overflow path; `done` at cycle 14, `is_fib`=0, `index`=13.
- `value`=233 started, `rst` pulsed at cycle 5 → no `done`; a new `start` with `value`=21 → `done` 9 cycles later, `index`=8. A `start` issued while `busy` is ignored.
